// File: rtl/hook_pkg.sv
// -----------------------------------------------------------------------------
// hook_pkg -- shared types and constants for the hook controller.
//
// Contents:
//   hook_state_t  : FSM state encoding (SWING=0, EXTEND=1, RETRACT=2, and
//                   PAUSED=3 only when HOOK_CTRL_PAUSE_EN is defined)
//   DEF_*         : default swing/extend limits and per-frame speeds
//   sat11()       : clamps a signed 12-bit intermediate into the 0..1023
//                   range of the 11-bit signed position outputs
// -----------------------------------------------------------------------------
package hook_pkg;

  localparam int DEF_X_MIN         = 40;
  localparam int DEF_X_MAX         = 560;
  localparam int DEF_Y_HOME        = 60;
  localparam int DEF_Y_MAX         = 440;
  localparam int DEF_SWING_SPEED   = 2;
  localparam int DEF_EXTEND_SPEED  = 4;
  localparam int DEF_RETRACT_SPEED = 6;

  typedef enum logic [1:0] {
    ST_SWING   = 2'd0,
    ST_EXTEND  = 2'd1,
`ifdef HOOK_CTRL_PAUSE_EN
    ST_RETRACT = 2'd2,
    ST_PAUSED  = 2'd3
`else
    ST_RETRACT = 2'd2
`endif
  } hook_state_t;

  // Positions are never negative and never exceed the 11-bit positive range.
  function automatic logic signed [10:0] sat11(input logic signed [11:0] v);
    logic signed [10:0] r;
    if (v < 12'sd0)
      r = 11'sd0;
    else if (v > 12'sd1023)
      r = 11'sd1023;
    else
      r = v[10:0];
    return r;
  endfunction

endpackage

// File: rtl/hook_ctrl.sv
// -----------------------------------------------------------------------------
// hook_ctrl -- Gold-Miner style hook: swings left/right, extends on fire,
// retracts (slowed by the weight of any grabbed object) and reports home.
//
// Optional feature: macro HOOK_CTRL_PAUSE_EN adds input pauseKey and the
// PAUSED state. Without it there is no pauseKey port and hookState never 3.
//
// Ports:
//   clk           : system clock, all state changes on its rising edge
//   reset         : asynchronous active-high reset
//   startOfFrame  : one-cycle pulse; every motion step happens only on it
//   fireKey       : level, launches the hook while swinging
//   collision     : hook overlaps a gold/rock object
//   grabWeight    : [3:0] slowdown of the grabbed object, latched on grab
//   pauseKey      : (HOOK_CTRL_PAUSE_EN only) freeze/resume on frame pulses
//   topLeftX/Y    : signed [10:0] registered hook position
//   hookState     : [1:0] current FSM state (also the debug view of the FSM)
//   grabbed       : an object is attached
//   retractDone   : one-cycle pulse when the hook arrives home
//
// Timing contract: there is no handshake. Inputs are sampled on the clk edge
// where startOfFrame=1; every output is a flop, so the frame's new position,
// state and grabbed flag are visible one clk after that edge. retractDone
// rises together with the arriving Y_HOME position; on the following clk the
// FSM returns to SWING and grabbed clears.
// -----------------------------------------------------------------------------
module hook_ctrl
  import hook_pkg::*;
#(
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_HOME        = DEF_Y_HOME,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int SWING_SPEED   = DEF_SWING_SPEED,
  parameter int EXTEND_SPEED  = DEF_EXTEND_SPEED,
  parameter int RETRACT_SPEED = DEF_RETRACT_SPEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               fireKey,
  input  logic               collision,
  input  logic [3:0]         grabWeight,
`ifdef HOOK_CTRL_PAUSE_EN
  input  logic               pauseKey,
`endif
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         hookState,
  output logic               grabbed,
  output logic               retractDone
);

  localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] Y_HOME_S = 12'(Y_HOME);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic signed [11:0] SWING_S  = 12'(SWING_SPEED);
  localparam logic signed [11:0] EXT_S    = 12'(EXTEND_SPEED);
  localparam logic signed [11:0] RET_S    = 12'(RETRACT_SPEED);

  hook_state_t        state_q, state_d;
`ifdef HOOK_CTRL_PAUSE_EN
  hook_state_t        saved_q, saved_d;
`endif
  logic signed [10:0] x_q, x_d;
  logic signed [10:0] y_q, y_d;
  logic               dir_q, dir_d;        // 1 = moving right
  logic               grabbed_q, grabbed_d;
  logic [3:0]         weight_q, weight_d;
  logic               done_q, done_d;

  // A frame pulse that actually advances motion (not consumed by pause logic).
  logic               frame_go;

  logic signed [11:0] x_ext, y_ext;
  logic signed [11:0] x_right, x_left;
  logic signed [11:0] y_down, y_down_c;
  logic signed [11:0] ret_raw, ret_step, y_up, y_up_c;

  // ---------------------------------------------------------------------------
  // Candidate positions in signed 12-bit, clamped to the motion limits.
  // ---------------------------------------------------------------------------
  assign x_ext    = {x_q[10], x_q};
  assign y_ext    = {y_q[10], y_q};
  assign x_right  = x_ext + SWING_S;
  assign x_left   = x_ext - SWING_S;
  assign y_down   = y_ext + EXT_S;
  assign y_down_c = (y_down >= Y_MAX_S) ? Y_MAX_S : y_down;
  // Heavy objects can push the raw step to zero or below; never stall.
  assign ret_raw  = RET_S - $signed({8'd0, weight_q});
  assign ret_step = (ret_raw < 12'sd1) ? 12'sd1 : ret_raw;
  assign y_up     = y_ext - ret_step;
  assign y_up_c   = (y_up <= Y_HOME_S) ? Y_HOME_S : y_up;

  // ---------------------------------------------------------------------------
  // State register (all flops).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SWING;
`ifdef HOOK_CTRL_PAUSE_EN
      saved_q   <= ST_SWING;
`endif
      x_q       <= sat11(X_MIN_S);
      y_q       <= sat11(Y_HOME_S);
      dir_q     <= 1'b1;
      grabbed_q <= 1'b0;
      weight_q  <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
`ifdef HOOK_CTRL_PAUSE_EN
      saved_q   <= saved_d;
`endif
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      grabbed_q <= grabbed_d;
      weight_q  <= weight_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    frame_go = 1'b0;
`ifdef HOOK_CTRL_PAUSE_EN
    saved_d  = saved_q;
`endif
    if (state_q == ST_RETRACT && done_q) begin
      // Cycle after the home pulse: back to swinging, independent of frames.
      state_d = ST_SWING;
    end else if (startOfFrame) begin
`ifdef HOOK_CTRL_PAUSE_EN
      if (state_q == ST_PAUSED) begin
        if (!pauseKey)
          state_d = saved_q;
      end else if (pauseKey) begin
        saved_d = state_q;
        state_d = ST_PAUSED;
      end else begin
        frame_go = 1'b1;
      end
`else
      frame_go = 1'b1;
`endif
      if (frame_go) begin
        case (state_q)
          ST_SWING:  if (fireKey) state_d = ST_EXTEND;
          // Collision or the step that lands on Y_MAX ends the extend.
          ST_EXTEND: if (collision || (y_down_c == Y_MAX_S)) state_d = ST_RETRACT;
          default:   ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output-register next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    grabbed_d = grabbed_q;
    weight_d  = weight_q;
    done_d    = 1'b0;
    case (state_q)
      ST_SWING: begin
        // The fire frame freezes X where it is.
        if (frame_go && !fireKey) begin
          if (dir_q) begin
            if (x_right >= X_MAX_S) begin
              x_d   = sat11(X_MAX_S);
              dir_d = 1'b0;
            end else begin
              x_d = sat11(x_right);
            end
          end else begin
            if (x_left <= X_MIN_S) begin
              x_d   = sat11(X_MIN_S);
              dir_d = 1'b1;
            end else begin
              x_d = sat11(x_left);
            end
          end
        end
      end
      ST_EXTEND: begin
        if (frame_go) begin
          if (collision) begin
            grabbed_d = 1'b1;
            weight_d  = grabWeight;
          end else begin
            y_d       = sat11(y_down_c);
            grabbed_d = 1'b0;
          end
        end
      end
      ST_RETRACT: begin
        if (done_q) begin
          grabbed_d = 1'b0;
          weight_d  = 4'd0;
        end else if (frame_go) begin
          y_d = sat11(y_up_c);
          if (y_up_c == Y_HOME_S)
            done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from flops.
  // ---------------------------------------------------------------------------
  assign topLeftX    = x_q;
  assign topLeftY    = y_q;
  assign hookState   = state_q;
  assign grabbed     = grabbed_q;
  assign retractDone = done_q;

endmodule

// File: tb/tb_hook_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hook_ctrl -- self-checking bench for hook_ctrl (default parameters).
// A frame-level reference model predicts the outputs after every frame pulse
// and the grabbed value at every home arrival; a monitor compares the DUT.
// -----------------------------------------------------------------------------
module tb_hook_ctrl;

  localparam int XMIN = 40, XMAX = 560, YHOME = 60, YMAX = 440;
  localparam int SW = 2, EX = 4, RT = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame;
  logic               fireKey;
  logic               collision;
  logic [3:0]         grabWeight;
`ifdef HOOK_CTRL_PAUSE_EN
  logic               pauseKey;
`endif
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0]         hookState;
  logic               grabbed, retractDone;

  hook_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .fireKey      (fireKey),
    .collision    (collision),
    .grabWeight   (grabWeight),
`ifdef HOOK_CTRL_PAUSE_EN
    .pauseKey     (pauseKey),
`endif
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .hookState    (hookState),
    .grabbed      (grabbed),
    .retractDone  (retractDone)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [24:0] exp_q[$];        // {state, x, y, grabbed} after each frame
  logic        done_exp_q[$];   // grabbed value expected with retractDone

  // ---------------- reference model (frame level) ----------------
  int mx, my, mdir, mstate, mgrab, mw, msaved;

  task automatic model_reset();
    mx = XMIN; my = YHOME; mdir = 1; mstate = 0; mgrab = 0; mw = 0; msaved = 0;
  endtask

  task automatic model_frame(input logic f, input logic c, input int w, input logic p);
    int nx, step;
    bit home;
    bit consumed;
    home = 0;
    consumed = 0;
`ifdef HOOK_CTRL_PAUSE_EN
    if (mstate == 3) begin
      if (!p) mstate = msaved;
      consumed = 1;
    end else if (p) begin
      msaved = mstate;
      mstate = 3;
      consumed = 1;
    end
`endif
    if (!consumed) begin
      if (mstate == 0) begin
        if (f) mstate = 1;
        else begin
          nx = mx + mdir * SW;
          if (nx >= XMAX) begin mx = XMAX; mdir = -1; end
          else if (nx <= XMIN) begin mx = XMIN; mdir = 1; end
          else mx = nx;
        end
      end else if (mstate == 1) begin
        if (c) begin mstate = 2; mgrab = 1; mw = w; end
        else begin
          my = (my + EX > YMAX) ? YMAX : my + EX;
          if (my == YMAX) begin mstate = 2; mgrab = 0; end
        end
      end else if (mstate == 2) begin
        step = (RT - mw < 1) ? 1 : RT - mw;
        my = (my - step < YHOME) ? YHOME : my - step;
        if (my == YHOME) home = 1;
      end
    end
    exp_q.push_back({2'(mstate), 11'(mx), 11'(my), 1'(mgrab)});
    if (home) begin
      done_exp_q.push_back(1'(mgrab));
      mstate = 0; mgrab = 0; mw = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_frame(input logic f, input logic c, input logic [3:0] w, input logic p);
    model_frame(f, c, int'(w), p);   // expectation queued before the pulse
    fireKey = f; collision = c; grabWeight = w;
`ifdef HOOK_CTRL_PAUSE_EN
    pauseKey = p;
`endif
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0; fireKey = 1'b0; collision = 1'b0;
`ifdef HOOK_CTRL_PAUSE_EN
    pauseKey = 1'b0;
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    startOfFrame = 1'b0; fireKey = 1'b0; collision = 1'b0; grabWeight = 4'd0;
`ifdef HOOK_CTRL_PAUSE_EN
    pauseKey = 1'b0;
`endif
    @(negedge clk);
    chk({tag, "_x"}, int'(topLeftX), XMIN);
    chk({tag, "_y"}, int'(topLeftY), YHOME);
    chk({tag, "_state"}, int'(hookState), 0);
    chk({tag, "_grabbed"}, int'(grabbed), 0);
    chk({tag, "_done"}, int'(retractDone), 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic sof_seen;
  always @(posedge clk or posedge reset) begin
    if (reset) sof_seen <= 1'b0;
    else       sof_seen <= startOfFrame;
  end

  always @(negedge clk) begin
    logic [24:0] e, g;
    logic        eg;
    if (!reset) begin
      if (sof_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: output update with no expectation");
        end else begin
          e = exp_q.pop_front();
          g = {hookState, topLeftX, topLeftY, grabbed};
          if (g !== e) begin
            errors++;
            $display("FAIL frame_outputs: got st=%0d x=%0d y=%0d g=%0d expected st=%0d x=%0d y=%0d g=%0d",
                     g[24:23], g[22:12], g[11:1], g[0], e[24:23], e[22:12], e[11:1], e[0]);
          end
        end
      end
      if (retractDone) begin
        checks++;
        if (done_exp_q.size() == 0) begin
          errors++;
          $display("FAIL retract_done_unexpected: got pulse with grabbed=%0d expected none", grabbed);
        end else begin
          eg = done_exp_q.pop_front();
          if (grabbed !== eg) begin
            errors++;
            $display("FAIL retract_done_grabbed: got %0d expected %0d", grabbed, eg);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int yp;
    model_reset();
    do_reset("reset");

    // Free sweep: 260 frames reach the right limit, 40 more come back to 480.
    for (int i = 0; i < 260; i++) do_frame(0, 0, 4'd0, 0);
    chk("sweep_right_limit", int'(topLeftX), XMAX);
    for (int i = 0; i < 40; i++) do_frame(0, 0, 4'd0, 0);
    chk("sweep_300_frames", int'(topLeftX), 480);

    // Fire at X=100 with no collision: full extend and retract.
    for (int i = 0; i < 400 && mx != 100; i++) do_frame(0, 0, 4'd0, 0);
    do_frame(1, 0, 4'd0, 0);
    for (int i = 0; i < 200 && mstate == 1; i++) do_frame(0, 0, 4'd0, 0);
    chk("extend_bottom_y", int'(topLeftY), YMAX);
    for (int i = 0; i < 200 && mstate == 2; i++) do_frame(1, 1, 4'd0, 0);
    chk("miss_x_frozen", int'(topLeftX), 100);

    // Collision at Y=200 with weight 4 (step 2), then weight 9 (step 1).
    for (int wsel = 0; wsel < 2; wsel++) begin
      do_frame(1, 0, 4'd0, 0);
      for (int i = 0; i < 200 && mstate == 1; i++)
        do_frame(0, (my == 200), (wsel == 0) ? 4'd4 : 4'd9, 0);
      chk("grab_flag", int'(grabbed), 1);
      yp = int'(topLeftY);
      do_frame(0, 0, 4'd0, 0);
      chk("grab_step", yp - int'(topLeftY), (wsel == 0) ? 2 : 1);
      for (int i = 0; i < 400 && mstate == 2; i++) do_frame(0, 0, 4'd0, 0);
    end

    // Collision on the same frame Y would land on Y_MAX: collision wins.
    do_frame(1, 0, 4'd0, 0);
    for (int i = 0; i < 200 && mstate == 1; i++)
      do_frame(0, (my == YMAX - EX), 4'($urandom_range(0, 15)), 0);
    chk("collision_at_bottom_grabbed", int'(grabbed), 1);
    chk("collision_at_bottom_y", int'(topLeftY), YMAX - EX);
    for (int i = 0; i < 400 && mstate == 2; i++) do_frame(0, 0, 4'd0, 0);

    // Randomized play.
    for (int i = 0; i < 300; i++)
      do_frame(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               4'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 400 && mstate != 0; i++) do_frame(0, 0, 4'd0, 0);

    // Reset in the middle of a retract.
    do_frame(1, 0, 4'd0, 0);
    for (int i = 0; i < 200 && mstate == 1; i++) do_frame(0, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) do_frame(0, 0, 4'd0, 0);
    do_reset("mid_retract_reset");
    do_frame(0, 0, 4'd0, 0);

`ifdef HOOK_CTRL_PAUSE_EN
    // Pause held for 10 frames during EXTEND, then resume.
    do_frame(1, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) do_frame(0, 0, 4'd0, 0);
    yp = int'(topLeftY);
    for (int i = 0; i < 10; i++) do_frame(0, 0, 4'd0, 1);
    chk("pause_y_held", int'(topLeftY), yp);
    chk("pause_state", int'(hookState), 3);
    do_frame(0, 0, 4'd0, 0);
    do_frame(0, 0, 4'd0, 0);
    chk("pause_resume_step", int'(topLeftY), yp + EX);
    for (int i = 0; i < 200 && mstate == 1; i++) do_frame(0, 0, 4'd0, 0);
    for (int i = 0; i < 400 && mstate == 2; i++) do_frame(0, 0, 4'd0, 0);
`endif

    repeat (5) @(negedge clk);
    chk("frames_left_unchecked", exp_q.size(), 0);
    chk("home_pulses_missing", done_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
